// File: rtl/dm_cache_pkg.sv
// Shared types for the direct-mapped L1 cache.
//   S_OFFSET / S_INDEX / S_TAG : address split (32 B lines, 8 sets, 24-bit tag)
//   tag_t, index_t, offset_t   : address field types
//   line_t                     : one 256-bit cache line
//   cache_state_t              : controller states
//   expand_be()                : word byte-enable -> per-byte line write mask
package cache_types;

  localparam int S_OFFSET   = 5;
  localparam int S_INDEX    = 3;
  localparam int S_TAG      = 32 - S_INDEX - S_OFFSET;
  localparam int LINE_BYTES = 1 << S_OFFSET;
  localparam int LINE_W     = 8 * LINE_BYTES;

  typedef logic [S_TAG-1:0]    tag_t;
  typedef logic [S_INDEX-1:0]  index_t;
  typedef logic [S_OFFSET-1:0] offset_t;
  typedef logic [LINE_W-1:0]   line_t;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } cache_state_t;

  // Place the 4 CPU byte lanes at the selected word within the line.
  function automatic logic [LINE_BYTES-1:0] expand_be(input logic [2:0] word,
                                                      input logic [3:0] be);
    expand_be = LINE_BYTES'(be) << {word, 2'b00};
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// Bus interfaces around the cache.
//   cpu_mem_if : CPU word port. master = CPU, slave = cache.
//                mem_address/mem_read/mem_write/mem_byte_enable/mem_wdata -> cache,
//                mem_rdata/mem_resp -> CPU.
//   pmem_if    : physical-memory line port. master = cache, slave = memory.
//                pmem_address/pmem_read/pmem_write/pmem_wdata -> memory,
//                pmem_rdata/pmem_resp -> cache.
interface cpu_mem_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
                  input  mem_rdata, mem_resp);
  modport slave  (input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
                  output mem_rdata, mem_resp);
endinterface

interface pmem_if;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (output pmem_address, pmem_read, pmem_write, pmem_wdata,
                  input  pmem_rdata, pmem_resp);
  modport slave  (input  pmem_address, pmem_read, pmem_write, pmem_wdata,
                  output pmem_rdata, pmem_resp);
endinterface

// File: rtl/dm_cache_array.sv
// Storage for the direct-mapped cache: valid/dirty bits (async reset),
// tag and data arrays (no reset). One set is addressed at a time.
//   clk, rst_n          : clock, async active-low reset (valid/dirty only)
//   idx                 : set being read/written
//   valid, dirty, tag, line : read-out of set idx (combinational)
//   wr_en, byte_we, wr_line : CPU write hit; byte_we selects line bytes, marks set dirty
//   load_en, load_tag, load_line : line fill; installs tag/data, valid=1, dirty=0
module cache_array
  import cache_types::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  index_t                idx,
  output logic                  valid,
  output logic                  dirty,
  output tag_t                  tag,
  output line_t                 line,
  input  logic                  wr_en,
  input  logic [LINE_BYTES-1:0] byte_we,
  input  line_t                 wr_line,
  input  logic                  load_en,
  input  tag_t                  load_tag,
  input  line_t                 load_line
);

  localparam int SETS = 1 << S_INDEX;

  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  tag_t            tag_mem  [SETS];
  line_t           data_mem [SETS];

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_mem[idx];
  assign line  = data_mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      // A write hit dirties the line even when no byte lane is enabled.
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      tag_mem[idx]  <= load_tag;
      data_mem[idx] <= load_line;
    end else begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (byte_we[b]) data_mem[idx][b*8 +: 8] <= wr_line[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache between the multicycle
// CPU and physical memory. Hits answer in the request cycle; misses write back
// a dirty victim line if needed, fill the line, then hit on return to CHECK.
//   clk   : clock
//   rst_n : async active-low reset (state, valid/dirty, pmem requests)
//   cpu   : cpu_mem_if.slave  -- CPU word requests, mem_rdata/mem_resp
//   pmem  : pmem_if.master    -- whole-line reads/writes to memory
module dm_cache
  import cache_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  cpu_mem_if.slave   cpu,
  pmem_if.master     pmem
);

  cache_state_t state_q;
  logic         pmem_read_q;
  logic         pmem_write_q;

  logic         req;
  logic         is_write;
  logic         hit;
  index_t       idx;
  tag_t         req_tag;
  logic [2:0]   word;

  logic         valid_r;
  logic         dirty_r;
  tag_t         tag_r;
  line_t        line_r;

  logic                  wr_en;
  logic [LINE_BYTES-1:0] byte_we;
  logic                  load_en;
  logic [31:0]           pmem_addr;
  logic                  unused_addr;

  assign req         = cpu.mem_read | cpu.mem_write;
  assign is_write    = cpu.mem_write;  // read+write together acts as a write
  assign idx         = cpu.mem_address[S_OFFSET +: S_INDEX];
  assign req_tag     = cpu.mem_address[31 -: S_TAG];
  assign word        = cpu.mem_address[4:2];
  assign unused_addr = ^cpu.mem_address[1:0];

  assign hit = req && valid_r && (tag_r == req_tag);

  assign wr_en   = (state_q == CHECK) && hit && is_write;
  assign byte_we = wr_en ? expand_be(word, cpu.mem_byte_enable) : '0;
  assign load_en = (state_q == FILL) && pmem.pmem_resp;

  cache_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .valid     (valid_r),
    .dirty     (dirty_r),
    .tag       (tag_r),
    .line      (line_r),
    .wr_en     (wr_en),
    .byte_we   (byte_we),
    .wr_line   ({(LINE_BYTES/4){cpu.mem_wdata}}),
    .load_en   (load_en),
    .load_tag  (req_tag),
    .load_line (pmem.pmem_rdata)
  );

  // Response is combinational so a hit costs no extra cycle.
  assign cpu.mem_resp  = (state_q == CHECK) && hit;
  assign cpu.mem_rdata = line_r[{word, 5'b00000} +: 32];

  always_comb begin
    pmem_addr = '0;
    case (state_q)
      WRITEBACK: pmem_addr = {tag_r, idx, {S_OFFSET{1'b0}}};
      FILL:      pmem_addr = {cpu.mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
      default:   pmem_addr = '0;
    endcase
  end

  assign pmem.pmem_address = pmem_addr;
  assign pmem.pmem_wdata   = line_r;
  assign pmem.pmem_read    = pmem_read_q;
  assign pmem.pmem_write   = pmem_write_q;

  // pmem_read/pmem_write are registered with the state so reset drops them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CHECK;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      case (state_q)
        CHECK: begin
          if (req && !hit) begin
            if (dirty_r) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
            end else begin
              state_q     <= FILL;
              pmem_read_q <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem.pmem_resp) begin
            state_q      <= FILL;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
          end
        end
        FILL: begin
          // Completes even if the CPU withdrew its request meanwhile.
          if (pmem.pmem_resp) begin
            state_q     <= CHECK;
            pmem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= CHECK;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
